// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the LFSR pattern generator stream.
// It seeds from a received word and confirms lock over several predictions.
// Once locked it flywheels its own sequence and counts word mismatches.

module prbs_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(8'hB8),
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [MW-1:0]    match_inc;
    logic [LW-1:0]    miss_inc;

    // One LFSR advance: shift left, tap parity enters the LSB.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & POLY)};
    endfunction

    assign match_inc = match_cnt_q + MW'(1);
    assign miss_inc  = miss_cnt_q + LW'(1);

    // Next-state logic: lock tracking, flywheel prediction and error counting.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    // The all-zero word is the LFSR lockup state and cannot seed.
                    if (data_in != '0) begin
                        exp_d       = step(data_in);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == exp_q) begin
                        match_cnt_d = match_inc;
                        exp_d       = step(data_in);
                        if (match_inc == MW'(LOCK_CNT)) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else if (data_in == '0) begin
                        state_d     = SEARCH;
                        exp_d       = '0;
                        match_cnt_d = '0;
                    end else begin
                        exp_d       = step(data_in);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Prediction runs on its own; received data never reseeds here.
                    exp_d = step(exp_q);
                    if (data_in == exp_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        miss_cnt_d = miss_inc;
                        if (miss_inc == LW'(LOSS_CNT)) begin
                            state_d     = SEARCH;
                            locked_d    = 1'b0;
                            exp_d       = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d     = SEARCH;
                    locked_d    = 1'b0;
                    exp_d       = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end

        // A clear wins over an increment in the same cycle.
        if (clr_err) begin
            err_count_d = '0;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            exp_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance plus a 2-bit-counter
// instance that reaches saturation without losing lock.

module tb_prbs_checker;

    logic        clk;
    logic        rst,  valid_in,  clr_err;
    logic [7:0]  data_in;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_o;

    logic        rst2, valid2, clr2;
    logic [7:0]  data2;
    logic        locked2, pulse2;
    logic [1:0]  count2;
    logic [1:0]  state2;

    int checks = 0;
    int errors = 0;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state_o   (state_o)
    );

    prbs_checker #(
        .WIDTH    (8),
        .POLY     (8'hB8),
        .LOCK_CNT (4),
        .LOSS_CNT (15),
        .ERR_W    (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst2),
        .valid_in  (valid2),
        .data_in   (data2),
        .clr_err   (clr2),
        .locked    (locked2),
        .err_pulse (pulse2),
        .err_count (count2),
        .state_o   (state2)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive the main instance on the falling edge, return just after the sampling edge.
    task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst = r; valid_in = v; data_in = d; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic el, input logic ep,
                                input logic [15:0] ec, input logic [1:0] es);
        check_val({tag, ".locked"}, 32'(locked), 32'(el));
        check_val({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
        check_val({tag, ".err_count"}, 32'(err_count), 32'(ec));
        check_val({tag, ".state"}, 32'(state_o), 32'(es));
    endtask

    task automatic apply_sat(input logic r, input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst2 = r; valid2 = v; data2 = d; clr2 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_sat(input string tag, input logic el, input logic ep, input logic [1:0] ec);
        check_val({tag, ".locked"}, 32'(locked2), 32'(el));
        check_val({tag, ".err_pulse"}, 32'(pulse2), 32'(ep));
        check_val({tag, ".err_count"}, 32'(count2), 32'(ec));
    endtask

    // Directed sequence; the LFSR words below are hand-stepped with taps B8.
    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = 8'h00; clr_err = 1'b0;
        rst2 = 1'b1; valid2 = 1'b0; data2 = 8'h00; clr2 = 1'b0;

        $display("[TB] reset");
        apply_stimulus(1, 0, 8'h00, 0);
        apply_stimulus(1, 0, 8'h00, 0);
        check_output("reset", 0, 0, 16'd0, 2'd0);

        $display("[TB] initial acquisition");
        apply_stimulus(0, 1, 8'h00, 0); check_output("acq.zero0", 0, 0, 16'd0, 2'd0);
        apply_stimulus(0, 1, 8'h00, 0); check_output("acq.zero1", 0, 0, 16'd0, 2'd0);
        apply_stimulus(0, 1, 8'h01, 0); check_output("acq.seed", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h02, 0); check_output("acq.m1", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h04, 0); check_output("acq.m2", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h08, 0); check_output("acq.m3", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h11, 0); check_output("acq.lock", 1, 0, 16'd0, 2'd2);

        $display("[TB] single corrupted word");
        apply_stimulus(0, 1, 8'h23, 0); check_output("err1.ok0", 1, 0, 16'd0, 2'd2);
        apply_stimulus(0, 1, 8'h47, 0); check_output("err1.ok1", 1, 0, 16'd0, 2'd2);
        apply_stimulus(0, 1, 8'hFF, 0); check_output("err1.bad", 1, 1, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'h1C, 0); check_output("err1.fly", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'h38, 0); check_output("err1.ok2", 1, 0, 16'd1, 2'd2);

        $display("[TB] valid gaps while locked");
        apply_stimulus(0, 0, 8'h00, 0); check_output("gap1.a", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'h71, 0); check_output("gap1.word", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 0, 8'hFF, 0); check_output("gap3.a", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 0, 8'h00, 0); check_output("gap3.b", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 0, 8'h5A, 0); check_output("gap3.c", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'hE2, 0); check_output("gap3.word", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 0, 8'h13, 0); check_output("gap2.a", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 0, 8'h00, 0); check_output("gap2.b", 1, 0, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'hC4, 0); check_output("gap2.word", 1, 0, 16'd1, 2'd2);

        $display("[TB] loss of lock and relock");
        apply_stimulus(0, 1, 8'hAA, 0); check_output("loss.bad1", 1, 1, 16'd2, 2'd2);
        apply_stimulus(0, 1, 8'hAA, 0); check_output("loss.bad2", 1, 1, 16'd3, 2'd2);
        apply_stimulus(0, 1, 8'hAA, 0); check_output("loss.bad3", 0, 1, 16'd4, 2'd0);
        apply_stimulus(0, 1, 8'h4B, 0); check_output("relock.seed", 0, 0, 16'd4, 2'd1);
        apply_stimulus(0, 1, 8'h97, 0); check_output("relock.m1", 0, 0, 16'd4, 2'd1);
        apply_stimulus(0, 1, 8'h2E, 0); check_output("relock.m2", 0, 0, 16'd4, 2'd1);
        apply_stimulus(0, 1, 8'h5C, 0); check_output("relock.m3", 0, 0, 16'd4, 2'd1);
        apply_stimulus(0, 1, 8'hB8, 0); check_output("relock.lock", 1, 0, 16'd4, 2'd2);

        $display("[TB] reset while locked");
        apply_stimulus(1, 1, 8'hAA, 0); check_output("rstlock", 0, 0, 16'd0, 2'd0);

        $display("[TB] zero word in verify");
        apply_stimulus(0, 1, 8'h01, 0); check_output("vzero.seed", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h00, 0); check_output("vzero.zero", 0, 0, 16'd0, 2'd0);

        $display("[TB] reseed in verify");
        apply_stimulus(0, 1, 8'h01, 0); check_output("reseed.seed", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h02, 0); check_output("reseed.m1", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h55, 0); check_output("reseed.bad", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'hAB, 0); check_output("reseed.m1b", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h57, 0); check_output("reseed.m2b", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'hAF, 0); check_output("reseed.m3b", 0, 0, 16'd0, 2'd1);
        apply_stimulus(0, 1, 8'h5F, 0); check_output("reseed.lock", 1, 0, 16'd0, 2'd2);
        apply_stimulus(0, 1, 8'h00, 0); check_output("reseed.err", 1, 1, 16'd1, 2'd2);
        apply_stimulus(0, 1, 8'h7C, 1); check_output("reseed.clr", 1, 0, 16'd0, 2'd2);

        $display("[TB] saturation on 2-bit counter");
        apply_sat(1, 0, 8'h00, 0);
        apply_sat(1, 0, 8'h00, 0); check_sat("sat.reset", 0, 0, 2'd0);
        apply_sat(0, 1, 8'h01, 0);
        apply_sat(0, 1, 8'h02, 0);
        apply_sat(0, 1, 8'h04, 0);
        apply_sat(0, 1, 8'h08, 0);
        apply_sat(0, 1, 8'h11, 0); check_sat("sat.lock", 1, 0, 2'd0);
        apply_sat(0, 1, 8'h00, 0); check_sat("sat.e1", 1, 1, 2'd1);
        apply_sat(0, 1, 8'h00, 0); check_sat("sat.e2", 1, 1, 2'd2);
        apply_sat(0, 1, 8'h00, 0); check_sat("sat.e3", 1, 1, 2'd3);
        apply_sat(0, 1, 8'h00, 0); check_sat("sat.e4", 1, 1, 2'd3);
        apply_sat(0, 1, 8'h00, 0); check_sat("sat.e5", 1, 1, 2'd3);
        apply_sat(0, 1, 8'h00, 1); check_sat("sat.clr", 1, 1, 2'd0);
        apply_sat(0, 1, 8'hE2, 0); check_sat("sat.fly", 1, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
